wb_port_arbiter: RTL and testbench

- Shares the register file's single write port between three writeback requesters: LINK (JAL return address), MEM (load data) and ALU (ALU result).
- Fixed priority LINK > MEM > ALU, with an anti-starvation promotion for ALU.
- Registers the winning write one cycle before it reaches register_file.
- Keeps a per-register busy scoreboard so the issue stage can stall on pending writebacks.

---
 rtl/wb_port_arbiter_pkg.sv | 25 ++
 rtl/wb_scoreboard.sv | 58 +++++
 rtl/wb_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg
//   Shared definitions for the writeback port arbiter slice: default datapath
//   widths, writeback source encodings, the JAL link register number and the
//   width of the ALU starvation counter.
package wb_port_arbiter_pkg;

    // Default widths of the core datapath.
    localparam int DEF_ISA_WIDTH           = 32;
    localparam int DEF_REG_FILE_ADDR_WIDTH = 5;

    // Register written by JAL with the return address.
    localparam int LINK_REG_NUM = 31;

    // Starvation counter width; STARVE_LIMIT must fit (1..15).
    localparam int STARVE_CNT_WIDTH = 4;

    // Writeback source index. SRC_NONE marks a cycle with no grant.
    typedef enum logic [1:0] {
        SRC_LINK = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_ALU  = 2'd2,
        SRC_NONE = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard
//   One pending-writeback bit per architectural register.
//   A reserve sets a bit, a commit clears one; when both target the same
//   register in the same cycle the reserve wins. Register 0 never goes busy.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   set_en       reserve strobe
//   set_addr     register being reserved
//   clr_en       commit strobe (register file write happening this edge)
//   clr_addr     register being committed
//   busy_mask    current pending bits, bit 0 is constant 0
module wb_scoreboard
    import wb_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_REG_FILE_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       set_en,
    input  logic [ADDR_WIDTH-1:0]      set_addr,
    input  logic                       clr_en,
    input  logic [ADDR_WIDTH-1:0]      clr_addr,
    output logic [2**ADDR_WIDTH-1:0]   busy_mask
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] busy_q;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) begin
            set_mask[set_addr] = 1'b1;
        end
        if (clr_en) begin
            clr_mask[clr_addr] = 1'b1;
        end
        // Clear first, then set: a same-register reserve survives the commit.
        busy_next = (busy_q & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_mask = busy_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register file write port between LINK, MEM and ALU writeback
//   requesters. Fixed priority LINK > MEM > ALU; an ALU request that has lost
//   STARVE_LIMIT consecutive cycles is promoted above everything. The winner
//   is registered and appears on wr_* one cycle after its grant. A busy
//   scoreboard tracks registers reserved by issue and not yet written back.
//
// Handshake: a transfer happens on a cycle where valid & ready are both high.
//   ready is combinational from the valids and the starvation count, at most
//   one ready is high, ready is never high without its valid, and a requester
//   keeps valid/addr/data stable until it sees ready.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   link_valid/ready/addr/data        JAL return-address writeback
//   mem_valid/ready/addr/data         load data writeback
//   alu_valid/ready/addr/data         ALU result writeback
//   rsv_valid, rsv_addr               issue-stage destination reservation
//   wr_en, wr_addr, wr_data           register file write port
//   busy_mask                         pending-writeback bit per register
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int ISA_WIDTH           = DEF_ISA_WIDTH,
    parameter int REG_FILE_ADDR_WIDTH = DEF_REG_FILE_ADDR_WIDTH,
    parameter int STARVE_LIMIT        = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              link_valid,
    output logic                              link_ready,
    input  logic [REG_FILE_ADDR_WIDTH-1:0]    link_addr,
    input  logic [ISA_WIDTH-1:0]              link_data,
    input  logic                              mem_valid,
    output logic                              mem_ready,
    input  logic [REG_FILE_ADDR_WIDTH-1:0]    mem_addr,
    input  logic [ISA_WIDTH-1:0]              mem_data,
    input  logic                              alu_valid,
    output logic                              alu_ready,
    input  logic [REG_FILE_ADDR_WIDTH-1:0]    alu_addr,
    input  logic [ISA_WIDTH-1:0]              alu_data,
    input  logic                              rsv_valid,
    input  logic [REG_FILE_ADDR_WIDTH-1:0]    rsv_addr,
    output logic                              wr_en,
    output logic [REG_FILE_ADDR_WIDTH-1:0]    wr_addr,
    output logic [ISA_WIDTH-1:0]              wr_data,
    output logic [2**REG_FILE_ADDR_WIDTH-1:0] busy_mask
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("wb_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_MAX = STARVE_CNT_WIDTH'(STARVE_LIMIT);

    logic [STARVE_CNT_WIDTH-1:0]   starve_cnt;
    logic                          promote;
    wb_src_e                       grant_src;
    logic [REG_FILE_ADDR_WIDTH-1:0] grant_addr;
    logic [ISA_WIDTH-1:0]          grant_data;

    // Grant selection. Readies are forced low during reset so nothing is
    // accepted while the write port and scoreboard are held cleared.
    always_comb begin
        promote    = alu_valid && (starve_cnt == STARVE_MAX);
        grant_src  = SRC_NONE;
        grant_addr = '0;
        grant_data = '0;

        if (!rst_n) begin
            grant_src = SRC_NONE;
        end else if (promote) begin
            grant_src = SRC_ALU;
        end else if (link_valid) begin
            grant_src = SRC_LINK;
        end else if (mem_valid) begin
            grant_src = SRC_MEM;
        end else if (alu_valid) begin
            grant_src = SRC_ALU;
        end

        case (grant_src)
            SRC_LINK: begin
                grant_addr = link_addr;
                grant_data = link_data;
            end
            SRC_MEM: begin
                grant_addr = mem_addr;
                grant_data = mem_data;
            end
            SRC_ALU: begin
                grant_addr = alu_addr;
                grant_data = alu_data;
            end
            default: begin
                grant_addr = '0;
                grant_data = '0;
            end
        endcase

        link_ready = (grant_src == SRC_LINK);
        mem_ready  = (grant_src == SRC_MEM);
        alu_ready  = (grant_src == SRC_ALU);
    end

    // Counts consecutive cycles an ALU request has been refused. Saturating
    // at the limit keeps promotion asserted until the ALU actually wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (alu_valid && !alu_ready) begin
            if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Write port register. A grant to register 0 is consumed but suppressed
    // here; address/data hold their last value on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (grant_src != SRC_NONE) begin
            wr_en   <= (grant_addr != '0);
            wr_addr <= grant_addr;
            wr_data <= grant_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // The commit clears on the same edge that writes the register file.
    wb_scoreboard #(
        .ADDR_WIDTH (REG_FILE_ADDR_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (rsv_valid && (rsv_addr != '0)),
        .set_addr  (rsv_addr),
        .clr_en    (wr_en),
        .clr_addr  (wr_addr),
        .busy_mask (busy_mask)
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//   Self-checking bench for wb_port_arbiter (STARVE_LIMIT = 4): a row table of
//   single-cycle input patterns with expected readies, hand sequences for the
//   multi-cycle cases, and an expected-write queue checked against the port.
module tb_wb_port_arbiter;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int NR  = 2**AW;
    localparam int LIM = 4;
    localparam int EW  = 1 + AW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          link_valid, link_ready, mem_valid, mem_ready, alu_valid, alu_ready;
    logic [AW-1:0] link_addr, mem_addr, alu_addr, rsv_addr, wr_addr;
    logic [DW-1:0] link_data, mem_data, alu_data, wr_data;
    logic          rsv_valid, wr_en;
    logic [NR-1:0] busy_mask;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .ISA_WIDTH           (DW),
        .REG_FILE_ADDR_WIDTH (AW),
        .STARVE_LIMIT        (LIM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .link_valid (link_valid),
        .link_ready (link_ready),
        .link_addr  (link_addr),
        .link_data  (link_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy_mask  (busy_mask)
    );

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic          lv;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        logic          mv;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          el;
        logic          em;
        logic          ea;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        link_valid = 1'b0; link_addr = '0; link_data = '0;
        mem_valid  = 1'b0; mem_addr  = '0; mem_data  = '0;
        alu_valid  = 1'b0; alu_addr  = '0; alu_data  = '0;
        rsv_valid  = 1'b0; rsv_addr  = '0;
    endtask

    // Called right after a negedge with inputs already applied. Checks the
    // readies, queues the expected write, then checks the port one cycle on.
    task automatic cycle(input string tag, input logic el, input logic em, input logic ea);
        logic [EW-1:0] e;
        #1;
        check($sformatf("%s link_ready", tag), link_ready, el);
        check($sformatf("%s mem_ready", tag), mem_ready, em);
        check($sformatf("%s alu_ready", tag), alu_ready, ea);
        e = '0;
        if (el)      e = {link_addr != '0, link_addr, link_data};
        else if (em) e = {mem_addr != '0, mem_addr, mem_data};
        else if (ea) e = {alu_addr != '0, alu_addr, alu_data};
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check($sformatf("%s exp_q empty", tag), 1, 0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("%s wr_en", tag), wr_en, e[EW-1]);
            if (e[EW-1]) begin
                check($sformatf("%s wr_addr", tag), wr_addr, e[EW-2 -: AW]);
                check($sformatf("%s wr_data", tag), wr_data, e[DW-1:0]);
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_q.delete();
        link_valid = 1'b1; link_addr = 5'd31;
        mem_valid  = 1'b1; mem_addr  = 5'd3;
        alu_valid  = 1'b1; alu_addr  = 5'd4;
        rsv_valid  = 1'b1; rsv_addr  = 5'd9;
        @(negedge clk);
        #1;
        check("rst link_ready", link_ready, 0);
        check("rst mem_ready", mem_ready, 0);
        check("rst alu_ready", alu_ready, 0);
        check("rst wr_en", wr_en, 0);
        check("rst wr_addr", wr_addr, 0);
        check("rst wr_data", wr_data, 0);
        check("rst busy_mask", busy_mask, 0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel wr_en", wr_en, 0);
        check("rel busy_mask", busy_mask, 0);
    endtask

    task automatic add_row(input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                           input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                           input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                           input logic el, input logic em, input logic ea);
        vec_t v;
        v.lv = lv; v.la = la; v.ld = ld;
        v.mv = mv; v.ma = ma; v.md = md;
        v.av = av; v.aa = aa; v.ad = ad;
        v.el = el; v.em = em; v.ea = ea;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();

        // Reset release, then one ALU write.
        apply_reset();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        cycle("alu5", 0, 0, 1);
        clear_inputs();
        cycle("idle0", 0, 0, 0);

        // Row table; losers keep their request for the following row.
        add_row(0, 0, 0,              0, 0, 0,      0, 0, 0,      0, 0, 0);
        add_row(1, 31, 32'h00400008,  0, 0, 0,      0, 0, 0,      1, 0, 0);
        add_row(0, 0, 0,              1, 3, 32'h33, 0, 0, 0,      0, 1, 0);
        add_row(0, 0, 0,              0, 0, 0,      1, 4, 32'h44, 0, 0, 1);
        add_row(1, 31, 32'h0040000c,  1, 6, 32'h66, 0, 0, 0,      1, 0, 0);
        add_row(0, 0, 0,              1, 6, 32'h66, 1, 7, 32'h77, 0, 1, 0);
        add_row(1, 31, 32'h00400010,  0, 0, 0,      1, 7, 32'h77, 1, 0, 0);
        add_row(1, 31, 32'h00400014,  1, 8, 32'h88, 1, 7, 32'h77, 1, 0, 0);
        add_row(0, 0, 0,              1, 8, 32'h88, 1, 7, 32'h77, 0, 1, 0);
        add_row(1, 31, 32'h00400018,  0, 0, 0,      1, 7, 32'h77, 0, 0, 1);
        add_row(1, 31, 32'h00400018,  0, 0, 0,      0, 0, 0,      1, 0, 0);
        add_row(0, 0, 0,              0, 0, 0,      1, 0, 32'hAA, 0, 0, 1);
        add_row(0, 0, 0,              0, 0, 0,      0, 0, 0,      0, 0, 0);
        apply_reset();
        foreach (vecs[i]) begin
            link_valid = vecs[i].lv; link_addr = vecs[i].la; link_data = vecs[i].ld;
            mem_valid  = vecs[i].mv; mem_addr  = vecs[i].ma; mem_data  = vecs[i].md;
            alu_valid  = vecs[i].av; alu_addr  = vecs[i].aa; alu_data  = vecs[i].ad;
            cycle($sformatf("row%0d", i), vecs[i].el, vecs[i].em, vecs[i].ea);
        end
        clear_inputs();

        // Priority: all three at once, drained over three consecutive writes.
        apply_reset();
        link_valid = 1'b1; link_addr = 5'd31; link_data = 32'h00400008;
        mem_valid  = 1'b1; mem_addr  = 5'd8;  mem_data  = 32'h11;
        alu_valid  = 1'b1; alu_addr  = 5'd9;  alu_data  = 32'h22;
        cycle("prio0", 1, 0, 0);
        link_valid = 1'b0;
        cycle("prio1", 0, 1, 0);
        mem_valid = 1'b0;
        cycle("prio2", 0, 0, 1);
        alu_valid = 1'b0;
        cycle("prio3", 0, 0, 0);

        // Starvation: MEM streams continuously, ALU is promoted on cycle 4,
        // and a fresh ALU request on cycle 5 is back at normal priority.
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            mem_valid = 1'b1;
            if (k < 5) begin
                mem_addr = AW'(16 + k);
                mem_data = $urandom;
            end
            alu_valid = 1'b1;
            if (k == 0) begin
                alu_addr = 5'd25;
                alu_data = $urandom_range(32'h0000FFFF, 32'h00000100);
            end
            if (k == 5) begin
                alu_addr = 5'd26;
                alu_data = $urandom_range(32'h0000FFFF, 32'h00000100);
            end
            cycle($sformatf("starve%0d", k), 0, (k != 4), (k == 4));
        end
        clear_inputs();
        cycle("starve_idle", 0, 0, 0);

        // Scoreboard: reserve wins over a same-cycle commit; a later commit
        // clears it while a different register is reserved.
        apply_reset();
        rsv_valid = 1'b1; rsv_addr = 5'd12;
        cycle("sb_rsv", 0, 0, 0);
        rsv_valid = 1'b0;
        check("sb busy after rsv", busy_mask, 32'h0000_1000);
        alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'h1212;
        cycle("sb_alu", 0, 0, 1);
        alu_valid = 1'b0;
        check("sb busy before commit", busy_mask, 32'h0000_1000);
        rsv_valid = 1'b1; rsv_addr = 5'd12;
        mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'h3434;
        cycle("sb_rerv", 0, 1, 0);
        mem_valid = 1'b0;
        check("sb busy reserve wins", busy_mask, 32'h0000_1000);
        rsv_addr = 5'd13;
        cycle("sb_clr", 0, 0, 0);
        rsv_valid = 1'b0;
        check("sb busy clear+set", busy_mask, 32'h0000_2000);

        // Register zero: grant accepted, no write, no busy bit.
        apply_reset();
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hBAD0;
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        cycle("zero", 0, 0, 1);
        clear_inputs();
        check("zero busy", busy_mask, 0);
        cycle("zero_idle", 0, 0, 0);
        check("zero busy idle", busy_mask, 0);

        // Asynchronous reset while a write to r7 is on the port.
        apply_reset();
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        cycle("ar_rsv", 0, 0, 0);
        rsv_valid = 1'b0;
        check("ar busy r7", busy_mask, 32'h0000_0080);
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h7777;
        #1;
        check("ar mem_ready", mem_ready, 1);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        @(negedge clk);
        check("ar wr_en pending", wr_en, 1);
        check("ar wr_addr pending", wr_addr, 7);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar wr_en dropped", wr_en, 0);
        check("ar busy dropped", busy_mask, 0);
        check("ar wr_addr dropped", wr_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            cycle($sformatf("ar_post%0d", k), 0, 0, 0);
        end
        check("ar busy final", busy_mask, 0);
        check("ar wr_addr final", wr_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
